// File: rtl/data_mem_responder.sv
// Single-port data memory that answers one load/store at a time after WAIT_CYCLES added cycles.
// Optional misaligned-access error response is enabled with the MISALIGN_ERR_EN macro.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int         DEPTH  = 1 << (ADDR_WIDTH - 2);
    localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state, state_nx;
    logic [3:0]              cnt;
    logic                    we_q, uns_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             wdata_q;
    logic [1:0]              size_q;
    logic                    accept, access;
    logic                    a_we, a_uns;
    logic [ADDR_WIDTH-1:0]   a_addr;
    logic [31:0]             a_wdata;
    logic [1:0]              a_size;
    logic [ADDR_WIDTH-3:0]   idx;
    logic [31:0]             word, ld_data, st_word;
    logic [7:0]              bsel;
    logic [15:0]             hsel;
    logic [3:0]              be;
    logic                    mis;
    logic                    unused_bits;
    logic [31:0]             mem [DEPTH];

    assign unused_bits = ^req_addr[31:ADDR_WIDTH];
    // req_ready stays low for as long as reset is held
    assign req_ready   = (state == IDLE) && reset;
    assign rsp_valid   = (state == RESP);
    assign accept      = req_ready && req_valid;

    // With zero wait cycles the access happens on the accept edge, so use the live inputs
    assign a_we    = (state == IDLE) ? req_we                    : we_q;
    assign a_addr  = (state == IDLE) ? req_addr[ADDR_WIDTH-1:0]  : addr_q;
    assign a_wdata = (state == IDLE) ? req_wdata                 : wdata_q;
    assign a_size  = (state == IDLE) ? req_size                  : size_q;
    assign a_uns   = (state == IDLE) ? req_unsigned              : uns_q;
    assign idx     = a_addr[ADDR_WIDTH-1:2];
    assign word    = mem[idx];
    assign bsel    = word[{a_addr[1:0], 3'b000} +: 8];
    assign hsel    = word[{a_addr[1], 4'b0000} +: 16];

    always_comb begin
        be      = 4'b0000;
        st_word = a_wdata;
        ld_data = word;
        mis     = 1'b0;
        case (a_size)
            2'b00: begin
                be[a_addr[1:0]] = 1'b1;
                st_word = {4{a_wdata[7:0]}};
                ld_data = a_uns ? {24'b0, bsel} : {{24{bsel[7]}}, bsel};
            end
            2'b01: begin
                be      = a_addr[1] ? 4'b1100 : 4'b0011;
                st_word = {2{a_wdata[15:0]}};
                ld_data = a_uns ? {16'b0, hsel} : {{16{hsel[15]}}, hsel};
            end
            default: be = 4'b1111;
        endcase
`ifdef MISALIGN_ERR_EN
        mis = ((a_size == 2'b01) && a_addr[0]) || (a_size[1] && (a_addr[1:0] != 2'b00));
`endif
    end

    always_comb begin
        state_nx = state;
        access   = 1'b0;
        case (state)
            IDLE: if (accept) begin
                if (WAIT_N == 4'd0) begin
                    state_nx = RESP;
                    access   = 1'b1;
                end else begin
                    state_nx = WAIT;
                end
            end
            WAIT: if (cnt == 4'd1) begin
                state_nx = RESP;
                access   = 1'b1;
            end
            RESP: if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt       <= 4'd0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'b0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            rsp_rdata <= 32'b0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                cnt     <= WAIT_N;
                we_q    <= req_we;
                addr_q  <= req_addr[ADDR_WIDTH-1:0];
                wdata_q <= req_wdata;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                rsp_rdata <= (a_we || mis) ? 32'b0 : ld_data;
                rsp_err   <= mis;
            end
        end
    end

    // Memory has no reset; an aborted access never reaches here because state is forced to IDLE
    always_ff @(posedge clock) begin
        if (access && a_we && !mis) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx][8*b +: 8] <= st_word[8*b +: 8];
        end
    end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 12, meaning byte-address bits decoded (memory = 2^(ADDR_WIDTH-2) 32-bit words).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, meaning added latency cycles per access (legal range 0-15).
REQ-003 The block SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid  input  1  the initiator presents a request.
REQ-006 The block SHALL have port req_ready  output  1  the responder can accept a request.
REQ-007 The block SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 The block SHALL have port req_addr  input  32  byte address.
REQ-009 The block SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 The block SHALL have port req_size  input  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-011 The block SHALL have port req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0.
REQ-012 The block SHALL have port rsp_valid  output  1  the response is valid.
REQ-013 The block SHALL have port rsp_ready  input  1  the initiator accepts the response.
REQ-014 The block SHALL have port rsp_rdata  output  32  load data, extended; 0 for stores.
REQ-015 The block SHALL have port rsp_err  output  1  error response flag.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-017 Acceptance SHALL occur on a cycle with req_valid=1 in IDLE; the block latches we/addr/wdata/size/unsigned and loads the wait counter with WAIT_CYCLES.
REQ-018 From IDLE after accept: go to WAIT if WAIT_CYCLES>0, else perform the access and go to RESP.
REQ-019 In WAIT the counter decrements each cycle; at count 1 the block performs the access and goes to RESP; rsp_valid rises exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-020 RESP SHALL hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready=1, then go to IDLE; a new request is accepted no earlier than the cycle after the handshake.
REQ-021 Word index SHALL be addr[ADDR_WIDTH-1:2]; bits above ADDR_WIDTH-1 are ignored (address wraps).
REQ-022 Byte lane SHALL be addr[1:0]; half lane SHALL be addr[1]; stores modify only the selected bytes; other bytes are unchanged.
REQ-023 Loads SHALL extract the selected byte/half and extend it to 32 bits per req_unsigned; word loads return the full word.
REQ-024 Input changes while not in IDLE SHALL be ignored (request fields are taken only from the latch).
REQ-025 Memory array contents SHALL be uninitialised and unaffected by reset.

Reset
REQ-026 reset=0 SHALL immediately force state IDLE, counter 0, req_ready=0 while asserted, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-027 On release, req_ready SHALL be 1 in the first cycle; reset mid-access SHALL abort it: a store not yet performed SHALL not write; a pending response is discarded.

Configuration
REQ-028 Macro MISALIGN_ERR_EN defined: half access with addr[0]=1 or word access with addr[1:0]!=0 SHALL not write memory and SHALL respond with rsp_err=1, rsp_rdata=0, same latency.
REQ-029 MISALIGN_ERR_EN undefined: rsp_err SHALL be tied 0; half ignores addr[0], word ignores addr[1:0].

Verification (WAIT_CYCLES=2)
REQ-030 Store word 0xDEADBEEF @0x010, then load word @0x010 -> rsp_rdata=0xDEADBEEF, rsp_valid 3 cycles after each accept.
REQ-031 Store byte 0x7F @0x013 over 0xDEADBEEF -> load word gives 0x7FADBEEF; signed load byte @0x012 gives 0xFFFFFFAD; unsigned gives 0x000000AD.
REQ-032 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready=0, a new req_valid is not accepted.
REQ-033 Store word 0x11111111 @0x1010 (ADDR_WIDTH=12) -> load word @0x010 returns 0x11111111 (wrap).
REQ-034 With MISALIGN_ERR_EN: store word 0x5 @0x011 -> rsp_err=1, word @0x010 unchanged; without: rsp_err=0, word @0x010 becomes 0x5.
REQ-035 Assert reset during WAIT of a store -> rsp_valid=0 immediately, the target word is unchanged, req_ready=1 the first cycle after release.
